// File: rtl/phys_free_list.sv
// Rename-stage physical tag allocator: circular free list, up to two grants per cycle, one release per retire.
// Grants are combinational from registered state; all-or-nothing with alloc_stall when short, flush rewinds head to commit_head.
module phys_free_list #(
    parameter int PHY_REGS  = 64,
    parameter int ARCH_REGS = 32,
    parameter int PHY_WIDTH = $clog2(PHY_REGS),
    parameter int FL_DEPTH  = PHY_REGS - ARCH_REGS,
    parameter int PTR_W     = $clog2(FL_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           alloc_req,
    output logic [1:0]           alloc_valid,
    output logic [PHY_WIDTH-1:0] alloc_phy_0,
    output logic [PHY_WIDTH-1:0] alloc_phy_1,
    output logic                 alloc_stall,
    input  logic                 retire_valid,
    input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
    output logic [PTR_W-1:0]     free_count,
    output logic                 overflow_err
);

    localparam int IDX_W = PTR_W - 1;

    logic [PHY_WIDTH-1:0] r_fl [FL_DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W-1:0]     r_commit_head;
    logic                 r_overflow_err;

    logic [PTR_W-1:0]     w_free_count;
    logic [PTR_W-1:0]     w_n;
    logic [PTR_W-1:0]     w_head_p1;
    logic [PTR_W-1:0]     w_commit_next;
    logic [IDX_W-1:0]     w_head_idx;
    logic [IDX_W-1:0]     w_head1_idx;
    logic [IDX_W-1:0]     w_tail_idx;
    logic                 w_full;
    logic                 w_grant;
    logic                 w_rel;

    assign w_free_count = r_tail - r_head;
    assign w_full       = (w_free_count == PTR_W'(FL_DEPTH));
    assign w_n          = PTR_W'(alloc_req[0]) + PTR_W'(alloc_req[1]);
    // Same-cycle releases are deliberately not bypassed into the grant decision.
    assign w_grant      = !flush && (w_free_count >= w_n);

    assign w_head_p1    = r_head + PTR_W'(1);
    assign w_head_idx   = r_head[IDX_W-1:0];
    assign w_head1_idx  = w_head_p1[IDX_W-1:0];
    assign w_tail_idx   = r_tail[IDX_W-1:0];

    assign w_rel         = retire_valid && !w_full;
    assign w_commit_next = retire_valid ? (r_commit_head + PTR_W'(1)) : r_commit_head;

    assign alloc_valid  = w_grant ? alloc_req : 2'b00;
    assign alloc_stall  = !w_grant && (alloc_req != 2'b00);
    assign alloc_phy_0  = r_fl[w_head_idx];
    // Lanes pack in order: lane 1 takes the first free tag when lane 0 is idle.
    assign alloc_phy_1  = alloc_req[0] ? r_fl[w_head1_idx] : r_fl[w_head_idx];
    assign free_count   = w_free_count;
    assign overflow_err = r_overflow_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fl[i] <= PHY_WIDTH'(ARCH_REGS + i);
            end
        end else if (w_rel) begin
            r_fl[w_tail_idx] <= rd_phy_old_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail         <= PTR_W'(FL_DEPTH);
            r_commit_head  <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_commit_head <= w_commit_next;
            if (w_rel) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (retire_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (flush) begin
            r_head <= w_commit_next;
        end else if (w_grant) begin
            r_head <= r_head + w_n;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: queue-level reference model checked every cycle plus literal spot checks.
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] alloc_req;
    logic [1:0] alloc_valid;
    logic [5:0] alloc_phy_0;
    logic [5:0] alloc_phy_1;
    logic       alloc_stall;
    logic       retire_valid;
    logic [5:0] rd_phy_old_commit;
    logic [5:0] free_count;
    logic       overflow_err;

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .alloc_req         (alloc_req),
        .alloc_valid       (alloc_valid),
        .alloc_phy_0       (alloc_phy_0),
        .alloc_phy_1       (alloc_phy_1),
        .alloc_stall       (alloc_stall),
        .retire_valid      (retire_valid),
        .rd_phy_old_commit (rd_phy_old_commit),
        .free_count        (free_count),
        .overflow_err      (overflow_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: free tags in hand-out order, and tags handed out but not yet retired.
    int free_q[$];
    int infl_q[$];
    bit m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int   n;
        bit   ok;
        bit   was_full;
        logic [1:0] ev;
        if (rst) begin
            free_q.delete();
            infl_q.delete();
            for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
            m_ovf = 1'b0;
        end else begin
            n  = int'(alloc_req[0]) + int'(alloc_req[1]);
            ok = !flush && (free_q.size() >= n);
            ev = ok ? alloc_req : 2'b00;
            chk("m_alloc_valid", 32'(alloc_valid), 32'(ev));
            chk("m_alloc_stall", 32'(alloc_stall), 32'(!ok && n != 0));
            chk("m_free_count", 32'(free_count), 32'(free_q.size()));
            chk("m_overflow_err", 32'(overflow_err), 32'(m_ovf));
            if (ev[0]) chk("m_alloc_phy_0", 32'(alloc_phy_0), 32'(free_q[0]));
            if (ev[1]) chk("m_alloc_phy_1", 32'(alloc_phy_1), 32'(ev[0] ? free_q[1] : free_q[0]));

            was_full = (free_q.size() == 32);
            if (ok) for (int k = 0; k < n; k++) infl_q.push_back(free_q.pop_front());
            if (retire_valid) begin
                if (was_full) m_ovf = 1'b1;
                else          free_q.push_back(int'(rd_phy_old_commit));
                if (infl_q.size() > 0) void'(infl_q.pop_front());
            end
            if (flush) begin
                free_q = {infl_q, free_q};
                infl_q.delete();
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic ret, input logic [5:0] tag, input logic fl);
        alloc_req         = req;
        retire_valid      = ret;
        rd_phy_old_commit = tag;
        flush             = fl;
    endtask

    task automatic do_reset;
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        tick();
        do_reset();

        // Reset state and dual-lane grant
        #2;
        chk("rst_free_count", 32'(free_count), 32'd32);
        chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
        chk("rst_alloc_stall", 32'(alloc_stall), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        tick();
        drive(2'b11, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t1_valid", 32'(alloc_valid), 32'd3);
        chk("t1_phy0", 32'(alloc_phy_0), 32'd32);
        chk("t1_phy1", 32'(alloc_phy_1), 32'd33);
        tick();
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t1_free", 32'(free_count), 32'd30);

        // Lane 1 alone takes the head tag
        do_reset();
        drive(2'b10, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t2_valid", 32'(alloc_valid), 32'd2);
        chk("t2_phy1", 32'(alloc_phy_1), 32'd32);
        tick();
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t2_free", 32'(free_count), 32'd31);

        // Drain to one tag, stall on a pair, then take the last
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(2'b11, 1'b0, 6'd0, 1'b0);
            tick();
        end
        drive(2'b01, 1'b0, 6'd0, 1'b0);
        tick();
        drive(2'b11, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t3_free1", 32'(free_count), 32'd1);
        chk("t3_stall_valid", 32'(alloc_valid), 32'd0);
        chk("t3_stall", 32'(alloc_stall), 32'd1);
        tick();
        drive(2'b01, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t3_last_valid", 32'(alloc_valid), 32'd1);
        chk("t3_last_phy0", 32'(alloc_phy_0), 32'd63);
        tick();
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t3_empty", 32'(free_count), 32'd0);

        // Empty list: release does not bypass, next cycle grants it from wrapped tail
        tick();
        drive(2'b01, 1'b1, 6'd5, 1'b0);
        #2;
        chk("t4_nobypass", 32'(alloc_valid), 32'd0);
        chk("t4_stall", 32'(alloc_stall), 32'd1);
        tick();
        drive(2'b01, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t4_valid", 32'(alloc_valid), 32'd1);
        chk("t4_phy0", 32'(alloc_phy_0), 32'd5);
        tick();

        // Flush rewinds to the committed head
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b0, 6'd0, 1'b0);
            tick();
        end
        drive(2'b00, 1'b1, 6'd1, 1'b0);
        tick();
        drive(2'b00, 1'b1, 6'd2, 1'b0);
        tick();
        drive(2'b11, 1'b0, 6'd0, 1'b1);
        #2;
        chk("t5_flush_valid", 32'(alloc_valid), 32'd0);
        tick();
        drive(2'b11, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t5_free", 32'(free_count), 32'd32);
        chk("t5_phy0", 32'(alloc_phy_0), 32'd34);
        chk("t5_phy1", 32'(alloc_phy_1), 32'd35);
        tick();

        // Release into a full list
        do_reset();
        drive(2'b00, 1'b1, 6'd7, 1'b0);
        tick();
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        #2;
        chk("t6_ovf", 32'(overflow_err), 32'd1);
        chk("t6_free", 32'(free_count), 32'd32);
        tick();
        #2;
        chk("t6_ovf_sticky", 32'(overflow_err), 32'd1);
        do_reset();
        #2;
        chk("t6_ovf_clr", 32'(overflow_err), 32'd0);
        tick();

        // Mixed traffic with wrap-around and periodic flushes, checked by the model
        for (int i = 0; i < 120; i++) begin
            drive(2'(i % 4), (infl_q.size() > 0) && (i % 3 != 0), 6'(i + 9), (i % 13) == 12);
            tick();
        end
        drive(2'b00, 1'b0, 6'd0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
